inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 31 +++
 rtl/inst_fetch_br_hold.sv | 44 ++++
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths, stall encoding, reset vector and bus payload types for the fetch stage.
package inst_fetch_pkg;

    localparam int unsigned STALL_BUS_WD = 6;
    localparam int unsigned BR_WD        = 33;
    localparam int unsigned IF_TO_ID_WD  = 33;
    localparam int unsigned PC_WD        = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // One word below the boot vector so the first increment lands on 0xBFC0_0000.
    localparam logic [PC_WD-1:0] PC_RESET_VEC = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic             br_e;
        logic [PC_WD-1:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic             ce;
        logic [PC_WD-1:0] pc;
    } if_to_id_t;

endpackage

// File: rtl/inst_fetch_br_hold.sv
// Remembers the first redirect seen while the PC is held and gives it priority on release.
module br_hold
    import inst_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             br_e_i,
    input  logic [PC_WD-1:0] br_addr_i,
    output logic             redirect_c_o,
    output logic [PC_WD-1:0] redirect_addr_c_o
);

    logic             pending_q, pending_d;
    logic [PC_WD-1:0] addr_q, addr_d;

    // Decode re-presents the same branch every stalled cycle, so only the first is captured.
    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        if (hold_i) begin
            if (br_e_i && !pending_q) begin
                pending_d = 1'b1;
                addr_d    = br_addr_i;
            end
        end else begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
        end
    end

    assign redirect_c_o      = pending_q | br_e_i;
    assign redirect_addr_c_o = pending_q ? addr_q : br_addr_i;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, redirect handling and SRAM request generation.
// Optional misaligned-fetch detection is enabled by defining INST_FETCH_ADEL_EN.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [BR_WD-1:0]        br_bus,
    output logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
    output logic                    inst_sram_en,
    output logic [3:0]              inst_sram_wen,
    output logic [PC_WD-1:0]        inst_sram_addr,
    output logic [PC_WD-1:0]        inst_sram_wdata,
    output logic                    fetch_adel
);

    br_bus_t          br;
    if_to_id_t        if_to_id;
    if_state_e        state_q, state_d;
    logic [PC_WD-1:0] pc_q, pc_d;
    logic             ce_q, ce_d;
    logic             hold_pc;
    logic             redirect_c;
    logic [PC_WD-1:0] redirect_addr_c;
    logic [PC_WD-1:0] next_pc_c;
    logic             unused_stall;

    assign br           = br_bus_t'(br_bus);
    assign hold_pc      = (stall[0] == STOP);
    assign unused_stall = ^stall[STALL_BUS_WD-1:1];

    br_hold u_br_hold (
        .clk               (clk),
        .rst_n             (rst),
        .hold_i            (hold_pc),
        .br_e_i            (br.br_e),
        .br_addr_i         (br.br_addr),
        .redirect_c_o      (redirect_c),
        .redirect_addr_c_o (redirect_addr_c)
    );

    assign next_pc_c = redirect_c ? redirect_addr_c : pc_q + PC_WD'(4);

    // Next-state and PC/ce update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        unique case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   if (hold_pc)  state_d = ST_HOLD;
            ST_HOLD:  if (!hold_pc) state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
        if (!hold_pc) begin
            pc_d = next_pc_c;
            ce_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RESET;
            pc_q    <= PC_RESET_VEC;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
        end
    end

    assign if_to_id.ce  = ce_q;
    assign if_to_id.pc  = pc_q;
    assign if_to_id_bus = IF_TO_ID_WD'(if_to_id);

`ifdef INST_FETCH_ADEL_EN
    assign fetch_adel   = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en = ce_q & ~fetch_adel;
`else
    assign fetch_adel   = 1'b0;
    assign inst_sram_en = ce_q;
`endif

    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized stall/redirect traffic.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic [32:0] br_bus = '0;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        fetch_adel;

    int errors = 0;
    int checks = 0;

    // Reference state: what the fetch stage must present, from the behavioural rules.
    logic [31:0] m_pc   = 32'hBFBF_FFFC;
    logic        m_ce   = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_paddr = 32'h0;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_adel      (fetch_adel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'hBFBF_FFFC; m_ce = 1'b0; m_pend = 1'b0; m_paddr = 32'h0;
        end else if (!stall[0]) begin
            if (m_pend)         m_pc = m_paddr;
            else if (br_bus[32]) m_pc = br_bus[31:0];
            else                m_pc = m_pc + 32'd4;
            m_ce = 1'b1;
            m_pend = 1'b0;
        end else if (br_bus[32] && !m_pend) begin
            m_pend = 1'b1;
            m_paddr = br_bus[31:0];
        end
    end

    function automatic logic m_adel();
`ifdef INST_FETCH_ADEL_EN
        return m_ce && (m_pc[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        check("bus",   if_to_id_bus,           {m_ce, m_pc});
        check("addr",  33'(inst_sram_addr),     33'(m_pc));
        check("en",    33'(inst_sram_en),       33'(m_ce & ~m_adel()));
        check("wen",   33'(inst_sram_wen),      33'd0);
        check("wdata", 33'(inst_sram_wdata),    33'd0);
        check("adel",  33'(fetch_adel),         33'(m_adel()));
    end

    task automatic drive(input logic s0, input logic be, input logic [31:0] ba);
        #2;
        stall  = {5'(0), s0};
        br_bus = {be, ba};
    endtask

    initial begin
        logic [31:0] ba;
        repeat (3) @(negedge clk);
        check("rst_state", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        #2 rst = 1'b1;
        @(negedge clk); check("boot0", if_to_id_bus, {1'b1, 32'hBFC0_0000});
        @(negedge clk); check("boot1", if_to_id_bus, {1'b1, 32'hBFC0_0004});
        repeat (3) @(negedge clk);
        check("pc10", if_to_id_bus, {1'b1, 32'hBFC0_0010});
        drive(1'b0, 1'b1, 32'hBFC0_0100);
        @(negedge clk); check("live_br", if_to_id_bus, {1'b1, 32'hBFC0_0100});
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk); check("live_br+4", if_to_id_bus, {1'b1, 32'hBFC0_0104});
        // Redirect captured while held, taken on release.
        drive(1'b1, 1'b1, 32'hBFC0_0200);
        repeat (3) @(negedge clk);
        check("stall_frozen", if_to_id_bus, {1'b1, 32'hBFC0_0104});
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk); check("stall_br", if_to_id_bus, {1'b1, 32'hBFC0_0200});
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk); check("stall_br+4", if_to_id_bus, {1'b1, 32'hBFC0_0204});
        // Second branch address while pending must be ignored, even on the release edge.
        drive(1'b1, 1'b1, 32'hBFC0_0200);
        @(negedge clk); drive(1'b1, 1'b1, 32'hBFC0_0300);
        @(negedge clk); drive(1'b1, 1'b1, 32'hBFC0_0300);
        @(negedge clk); drive(1'b0, 1'b1, 32'hBFC0_0300);
        @(negedge clk); check("dbl_br", if_to_id_bus, {1'b1, 32'hBFC0_0200});
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); check("top_addr", if_to_id_bus, {1'b1, 32'hFFFF_FFFC});
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk); check("wrap", if_to_id_bus, {1'b1, 32'h0000_0000});
        // Reset while a redirect is pending: no replay after release.
        drive(1'b1, 1'b1, 32'hBFC0_0500);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); check("mid_rst", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        drive(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk); check("rst_rel0", if_to_id_bus, {1'b1, 32'hBFC0_0000});
        @(negedge clk); check("rst_rel1", if_to_id_bus, {1'b1, 32'hBFC0_0004});
        drive(1'b0, 1'b1, 32'hBFC0_0402);
        @(negedge clk);
        check("mis_pc", if_to_id_bus, {1'b1, 32'hBFC0_0402});
`ifdef INST_FETCH_ADEL_EN
        check("mis_adel", 33'(fetch_adel), 33'd1);
        check("mis_en",   33'(inst_sram_en), 33'd0);
`else
        check("mis_adel", 33'(fetch_adel), 33'd0);
        check("mis_en",   33'(inst_sram_en), 33'd1);
`endif
        drive(1'b0, 1'b0, 32'h0);
        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0), ba);
            stall[5:1] = 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
